// File: rtl/tt_scan.sv
// Self-timed truth-table scanner: sweeps every input combination, samples f_in after SETTLE cycles.
// Optional expected-table comparison is compiled in with `define TT_SCAN_COMPARE_EN.
module tt_scan #(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_VARS-1:0]        vars,
  input  logic                     f_in,
  output logic                     busy,
  output logic                     done,
  output logic [(1<<N_VARS)-1:0]   table_out,
  output logic [N_VARS:0]          ones_count,
  input  logic [(1<<N_VARS)-1:0]   exp_table,
  output logic                     mismatch,
  output logic [N_VARS-1:0]        first_fail
);

  localparam int                ROWS       = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST_IDX   = N_VARS'(ROWS - 1);
  localparam logic [3:0]        SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [N_VARS-1:0]   idx_q;
  logic [3:0]          cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [ROWS-1:0]     table_q;
  logic [N_VARS:0]     ones_q;

  logic accept;
  logic sample_en;

  assign accept    = (state_q == IDLE) && start;
  assign sample_en = (state_q == RUN) && (cnt_q == 4'd0);

  // idx_q doubles as the vars output; it is forced back to 0 whenever the scan is not running.
  // NOTE: all state here is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking writes would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= SETTLE_CNT;
            busy_q  <= 1'b1;
            table_q <= '0;
            ones_q  <= '0;
          end
        end
        RUN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            table_q[idx_q] <= f_in;
            ones_q         <= ones_q + (N_VARS+1)'(f_in);
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + N_VARS'(1);
              cnt_q <= SETTLE_CNT;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vars       = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign ones_count = ones_q;

`ifdef TT_SCAN_COMPARE_EN
  logic              mismatch_q;
  logic [N_VARS-1:0] first_fail_q;

  // Only the first differing row is latched; the sweep is ascending, so it is the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q   <= 1'b0;
      first_fail_q <= '0;
    end else if (accept) begin
      mismatch_q   <= 1'b0;
      first_fail_q <= '0;
    end else if (sample_en && (f_in != exp_table[idx_q]) && !mismatch_q) begin
      mismatch_q   <= 1'b1;
      first_fail_q <= idx_q;
    end
  end

  assign mismatch   = mismatch_q;
  assign first_fail = first_fail_q;
`else
  logic unused_cmp;

  assign unused_cmp = ^{exp_table, accept, sample_en};
  assign mismatch   = 1'b0;
  assign first_fail = '0;
`endif

endmodule

// File: tb/tb_tt_scan.sv
// Directed bench for tt_scan: N_VARS=3/SETTLE=1 against f=(x|~y)&(~y|~z), plus a SETTLE=0 instance with f_in=1.
module tb_tt_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] vars;
  logic       f_in;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic [3:0] ones_count;
  logic [7:0] exp_table;
  logic       mismatch;
  logic [2:0] first_fail;

  logic       start0;
  logic [2:0] vars0;
  logic       busy0;
  logic       done0;
  logic [7:0] table0;
  logic [3:0] ones0;
  logic       mismatch0;
  logic [2:0] first_fail0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // x = vars[2], y = vars[1], z = vars[0]
  assign f_in = (vars[2] | ~vars[1]) & (~vars[1] | ~vars[0]);

  tt_scan #(.N_VARS(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vars(vars), .f_in(f_in),
    .busy(busy), .done(done), .table_out(table_out), .ones_count(ones_count),
    .exp_table(exp_table), .mismatch(mismatch), .first_fail(first_fail)
  );

  tt_scan #(.N_VARS(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vars(vars0), .f_in(1'b1),
    .busy(busy0), .done(done0), .table_out(table0), .ones_count(ones0),
    .exp_table(8'h00), .mismatch(mismatch0), .first_fail(first_fail0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then waits (bounded) for done; lat = cycles after the accepting edge, 0 on timeout.
  task automatic scan_to_done(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; exp_table = 8'h00;
    tick(); tick();
    n_tests++;
    if ({vars, busy, done, table_out, ones_count, mismatch, first_fail} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_hold: vars=%h busy=%b done=%b table=%h ones=%0d mm=%b ff=%0d, want all 0",
               vars, busy, done, table_out, ones_count, mismatch, first_fail);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({vars, busy, done, table_out, ones_count} !== 19'd0 || {vars0, busy0, done0, table0, ones0} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_release: vars=%h busy=%b done=%b table=%h ones=%0d table0=%h, want all 0",
               vars, busy, done, table_out, ones_count, table0);
    end
  endtask

  task automatic test_sweep;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) tick();
      n_tests++;
      if (vars !== 3'(c / 2) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_cycle%0d: vars=%0d busy=%b done=%b, want vars=%0d busy=1 done=0",
                 c, vars, busy, done, c / 2);
      end
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || vars !== 3'd0) begin
      n_fail++;
      $display("FAIL sweep_done16: done=%b busy=%b vars=%0d, want done=1 busy=0 vars=0", done, busy, vars);
    end
    n_tests++;
    if (table_out !== 8'h73 || ones_count !== 4'd5) begin
      n_fail++;
      $display("FAIL sweep_result: table=%h ones=%0d, want 73 and 5", table_out, ones_count);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || table_out !== 8'h73 || ones_count !== 4'd5) begin
      n_fail++;
      $display("FAIL sweep_hold: done=%b table=%h ones=%0d, want 0 73 5", done, table_out, ones_count);
    end
  endtask

  task automatic test_compare;
    int lat;
    exp_table = 8'h73;
    scan_to_done(lat);
`ifdef TT_SCAN_COMPARE_EN
    n_tests++;
    if (lat != 16 || mismatch !== 1'b0 || first_fail !== 3'd0) begin
      n_fail++;
      $display("FAIL cmp_match: lat=%0d mm=%b ff=%0d, want 16 0 0", lat, mismatch, first_fail);
    end
    tick(); tick();
    exp_table = 8'h77;
    scan_to_done(lat);
    n_tests++;
    if (lat != 16 || mismatch !== 1'b1 || first_fail !== 3'd2 || table_out !== 8'h73) begin
      n_fail++;
      $display("FAIL cmp_diff: lat=%0d mm=%b ff=%0d table=%h, want 16 1 2 73", lat, mismatch, first_fail, table_out);
    end
`else
    n_tests++;
    if (lat != 16 || mismatch !== 1'b0 || first_fail !== 3'd0) begin
      n_fail++;
      $display("FAIL cmp_off_match: lat=%0d mm=%b ff=%0d, want 16 0 0", lat, mismatch, first_fail);
    end
    tick(); tick();
    exp_table = 8'h77;
    scan_to_done(lat);
    n_tests++;
    if (lat != 16 || mismatch !== 1'b0 || first_fail !== 3'd0) begin
      n_fail++;
      $display("FAIL cmp_off_diff: lat=%0d mm=%b ff=%0d, want 16 0 0", lat, mismatch, first_fail);
    end
`endif
    tick(); tick();
  endtask

  task automatic test_restart_ignored;
    int first_done = 0;
    int n_done = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      start = (c == 5);
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
    end
    start = 1'b0;
    n_tests++;
    if (first_done != 16 || n_done != 1 || table_out !== 8'h73) begin
      n_fail++;
      $display("FAIL restart_ignored: first_done=%0d pulses=%0d table=%h, want 16 1 73",
               first_done, n_done, table_out);
    end
  endtask

  task automatic test_reset_mid;
    int n_done = 0;
    int lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    n_tests++;
    if (table_out !== 8'h03 || ones_count !== 4'd2 || vars !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_progress: table=%h ones=%0d vars=%0d, want 03 2 4", table_out, ones_count, vars);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({vars, busy, done, table_out, ones_count, mismatch, first_fail} !== 23'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: vars=%0d busy=%b done=%b table=%h ones=%0d, want all 0",
               vars, busy, done, table_out, ones_count);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_done: pulses=%0d busy=%b, want 0 0", n_done, busy);
    end
    scan_to_done(lat);
    n_tests++;
    if (lat != 16 || table_out !== 8'h73 || ones_count !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_rescan: lat=%0d table=%h ones=%0d, want 16 73 5", lat, table_out, ones_count);
    end
    tick(); tick();
  endtask

  task automatic test_settle0;
    int lat = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done0 === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_tests++;
    if (lat != 8 || table0 !== 8'hFF || ones0 !== 4'd8 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL settle0: lat=%0d table=%h ones=%0d busy=%b, want 8 FF 8 0", lat, table0, ones0, busy0);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    int first_done = 0;
    int second_done = 0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 16) begin
        n_tests++;
        if (done !== 1'b1 || table_out !== 8'h73) begin
          n_fail++;
          $display("FAIL b2b_first: done=%b table=%h, want 1 73", done, table_out);
        end
      end
      if (c == 17) begin
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap: busy=%b done=%b, want 0 0", busy, done);
        end
      end
      if (c == 18) begin
        n_tests++;
        if (busy !== 1'b1 || table_out !== 8'h00 || ones_count !== 4'd0) begin
          n_fail++;
          $display("FAIL b2b_restart: busy=%b table=%h ones=%0d, want 1 00 0", busy, table_out, ones_count);
        end
        start = 1'b0;
      end
      if (done === 1'b1) begin
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
    end
    n_tests++;
    if (first_done != 16 || second_done != 34 || table_out !== 8'h73) begin
      n_fail++;
      $display("FAIL b2b_second: done at %0d and %0d, table=%h, want 16 34 73", first_done, second_done, table_out);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    tick(); tick();
    test_compare();
    test_restart_ignored();
    tick(); tick();
    test_reset_mid();
    test_settle0();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_scan.md
# tt_scan

Sequential truth-table scanner that sits directly upstream of the combinational function blocks in the guide exercises. On a start pulse it drives every input combination of an N-variable function in ascending binary order, waits a programmable settle time, and samples the function output into a packed truth-table register. The block replaces hand-written `#1` stimulus lists with a clocked, self-timed sweep whose result is a single vector plus summary flags.

## Interface
- `N_VARS`, default 3: number of function inputs (1..5).
- `SETTLE`, default 1: idle cycles between applying a combination and sampling the output (0..15).
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a scan; sampled only in IDLE.
- `vars` output N_VARS: current input combination to the function; `vars[N_VARS-1]` is the leftmost variable (x), `vars[0]` the rightmost (z).
- `f_in` input 1: function output, e.g. `s` of the three-input block.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when a scan completes.
- `table_out` output 2^N_VARS: bit i = function value for `vars == i`.
- `ones_count` output N_VARS+1: number of 1 bits in `table_out` (minterm count).
- `exp_table` input 2^N_VARS: expected truth table (used only with the compare feature).
- `mismatch` output 1: `table_out != exp_table` after last scan.
- `first_fail` output N_VARS: lowest row index where result differs from expected.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `busy`=0, `vars`=0. `start`=1 at a rising edge -> RUN; same edge: `idx`<=0, settle counter<=SETTLE, `table_out`<=0, `ones_count`<=0, `mismatch`<=0, `first_fail`<=0, `busy`<=1.
- RUN: `vars` = `idx` (registered). If counter != 0: decrement. If counter == 0: write `f_in` into `table_out[idx]`, add it to `ones_count`; if `idx` == 2^N_VARS-1 -> DONE, else `idx`<=`idx`+1 and counter<=SETTLE.
- DONE: one cycle; `done`=1, `busy`=0; -> IDLE. `vars` returns to 0.
- `start` while RUN or DONE is ignored (not queued).
- `table_out`, `ones_count`, `mismatch`, `first_fail` hold their values from the last completed scan until the next accepted `start`.
- `ones_count` is accumulated one bit per sample; it never wraps (max 2^N_VARS fits in N_VARS+1 bits).
- Reset (any time, including mid-scan): state IDLE, `idx`=0, all outputs 0 immediately; scan is abandoned, no `done`.

## Timing
- Each combination occupies exactly SETTLE+1 cycles in RUN; `vars` is stable for that whole window.
- Scan latency: accepting edge to `done` high = 2^N_VARS·(SETTLE+1) cycles; N_VARS=3, SETTLE=1 -> `done` asserted 16 cycles after the accepting edge.
- `f_in` is assumed combinationally derived from `vars`; with SETTLE=0 it is sampled in the same cycle the combination is presented.
- Back-to-back: a `start` held high through DONE is accepted on the first IDLE edge, giving one idle cycle between scans.

## Configuration
- `TT_SCAN_COMPARE_EN` defined: each sample is compared with `exp_table[idx]`; on the first difference `mismatch`<=1 and `first_fail`<=`idx`; later differences do not change `first_fail`.
- Not defined: comparison logic absent; `mismatch` and `first_fail` are constant 0; `exp_table` is unused.

## Test plan
- Reset with `rst_n`=0, then release -> `vars`=0, `busy`=0, `done`=0, `table_out`=0, `ones_count`=0.
- N_VARS=3, SETTLE=1, `f_in` = (x | ~y) & (~y | ~z), pulse `start` -> `vars` steps 0..7, two cycles each; `done` 16 cycles later; `table_out`=8'h73, `ones_count`=5.
- Same, `TT_SCAN_COMPARE_EN`, `exp_table`=8'h73 -> `mismatch`=0, `first_fail`=0; `exp_table`=8'h77 -> `mismatch`=1, `first_fail`=2.
- `start` re-pulsed at cycle 5 of a scan -> ignored; `done` still at cycle 16, exactly one `done` pulse.
- `rst_n` low at cycle 9 of a scan -> outputs 0 at once; no `done`; fresh `start` afterwards produces a full, correct 8'h73 result.
- SETTLE=0, `f_in` tied 1 -> `done` 8 cycles after start, `table_out`=8'hFF, `ones_count`=8.
